// File: rtl/itr_pkg.sv
// Shared types, default sizes and the vector-address helper for the itr_ctrl interrupt controller.
package itr_pkg;

    localparam int unsigned NITR_DEF   = 4;
    localparam int unsigned MINSTW_DEF = 9;
    localparam int unsigned ITRADD_DEF = 1;
    localparam int unsigned ITRSTP_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Index width; kept at least 1 bit so a degenerate source count still elaborates.
    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned depth_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Full 32-bit result; the caller truncates it to the instruction address width.
    function automatic logic [31:0] vec_addr(input int unsigned base,
                                             input int unsigned stp,
                                             input int unsigned id);
        return 32'(base + stp * id);
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit finder: index of the lowest set bit of vec, plus a valid flag.
module prio_enc #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx_c,
    output logic          vld_c
);

    // Scan downward so the lowest set index is the one that sticks.
    always_comb begin
        idx_c = '0;
        vld_c = |vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx_c = IW'(i);
            end
        end
    end

endmodule

// File: rtl/itr_ctrl.sv
// Multi-source vectored interrupt controller with in-service tracking.
// Define ITR_NEST_EN to allow strict-priority nested preemption; otherwise one ISR at a time.
module itr_ctrl
    import itr_pkg::*;
#(
    parameter int unsigned       NITR   = NITR_DEF,
    parameter int unsigned       MINSTW = MINSTW_DEF,
    parameter int unsigned       ITRADD = ITRADD_DEF,
    parameter int unsigned       ITRSTP = ITRSTP_DEF,
    parameter logic [NITR-1:0]   ITRMOD = {NITR{1'b1}}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NITR-1:0]               irq,
    input  logic                          mask_wr,
    input  logic [NITR-1:0]               mask_in,
    input  logic                          gie_wr,
    input  logic                          gie_in,
    output logic                          itr,
    output logic [MINSTW-1:0]             itr_addr,
    output logic [id_w(NITR)-1:0]         itr_id,
    input  logic                          itr_ack,
    input  logic                          itr_ret,
    output logic [NITR-1:0]               pend,
    output logic [NITR-1:0]               isr,
    output logic [depth_w(NITR)-1:0]      depth
);

    localparam int unsigned IDW  = id_w(NITR);
    localparam int unsigned DEPW = depth_w(NITR);

    state_t            state;
    state_t            state_nxt;
    logic              itr_nxt;
    logic [IDW-1:0]    id_nxt;
    logic [MINSTW-1:0] addr_nxt;

    logic [NITR-1:0]   irq_d;
    logic [NITR-1:0]   mask;
    logic              gie;

    logic [NITR-1:0]   nest_ok_c;
    logic [NITR-1:0]   elig_c;
    logic [NITR-1:0]   ack_set_c;
    logic [NITR-1:0]   ret_clr_c;
    logic [IDW-1:0]    win_idx_c;
    logic [IDW-1:0]    isr_idx_c;
    logic              win_vld_c;
    logic              isr_vld_c;
    logic              ack_fire_c;
    logic              ret_fire_c;

    prio_enc #(.N(NITR), .IW(IDW)) u_win_enc (
        .vec   (elig_c),
        .idx_c (win_idx_c),
        .vld_c (win_vld_c)
    );

    prio_enc #(.N(NITR), .IW(IDW)) u_isr_enc (
        .vec   (isr),
        .idx_c (isr_idx_c),
        .vld_c (isr_vld_c)
    );

    assign ack_fire_c = (state == REQ) && itr_ack;
    assign ret_fire_c = itr_ret && isr_vld_c;
    assign ack_set_c  = ack_fire_c ? (NITR'(1) << itr_id) : '0;
    assign ret_clr_c  = ret_fire_c ? (NITR'(1) << isr_idx_c) : '0;

`ifdef ITR_NEST_EN
    // Only sources strictly above the highest-priority active ISR may preempt.
    assign nest_ok_c = isr_vld_c ? ((NITR'(1) << isr_idx_c) - NITR'(1)) : '1;
`else
    assign nest_ok_c = isr_vld_c ? '0 : '1;
`endif

    assign elig_c = pend & ~mask & {NITR{gie}} & nest_ok_c;

    // Input history, mask and global enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_d <= '0;
            mask  <= '1;
            gie   <= 1'b0;
        end else begin
            irq_d <= irq;
            if (mask_wr) mask <= mask_in;
            if (gie_wr)  gie  <= gie_in;
        end
    end

    // Edge sources latch until acked (a fresh edge wins over the ack); level sources follow irq.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            for (int k = 0; k < NITR; k++) begin
                if (ITRMOD[k]) begin
                    pend[k] <= (pend[k] & ~ack_set_c[k]) | (irq[k] & ~irq_d[k]);
                end else begin
                    pend[k] <= irq[k];
                end
            end
        end
    end

    // In-service tracking: a return clears the old lowest bit before the ack bit is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            isr   <= '0;
            depth <= '0;
        end else begin
            isr <= (isr & ~ret_clr_c) | ack_set_c;
            case ({ack_fire_c, ret_fire_c})
                2'b10:   depth <= depth + DEPW'(1);
                2'b01:   depth <= depth - DEPW'(1);
                default: depth <= depth;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            itr      <= 1'b0;
            itr_id   <= '0;
            itr_addr <= MINSTW'(ITRADD);
        end else begin
            state    <= state_nxt;
            itr      <= itr_nxt;
            itr_id   <= id_nxt;
            itr_addr <= addr_nxt;
        end
    end

    // Request FSM: the issued request is frozen until the core acknowledges it.
    always_comb begin
        state_nxt = state;
        itr_nxt   = itr;
        id_nxt    = itr_id;
        addr_nxt  = itr_addr;
        case (state)
            IDLE: begin
                if (win_vld_c) begin
                    state_nxt = REQ;
                    itr_nxt   = 1'b1;
                    id_nxt    = win_idx_c;
                    addr_nxt  = MINSTW'(vec_addr(ITRADD, ITRSTP, 32'(win_idx_c)));
                end
            end
            REQ: begin
                if (itr_ack) begin
                    state_nxt = IDLE;
                    itr_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                itr_nxt   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_itr_ctrl.sv
// Scoreboarded bench for itr_ctrl; source 1 is built as a level source, the rest are edge sources.
module tb_itr_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq;
    logic       mask_wr;
    logic [3:0] mask_in;
    logic       gie_wr;
    logic       gie_in;
    logic       itr;
    logic [8:0] itr_addr;
    logic [1:0] itr_id;
    logic       itr_ack;
    logic       itr_ret;
    logic [3:0] pend;
    logic [3:0] isr;
    logic [2:0] depth;

    typedef struct {
        logic [1:0] id;
        logic [8:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    itr_ctrl #(
        .NITR   (4),
        .MINSTW (9),
        .ITRADD (1),
        .ITRSTP (4),
        .ITRMOD (4'b1101)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .irq      (irq),
        .mask_wr  (mask_wr),
        .mask_in  (mask_in),
        .gie_wr   (gie_wr),
        .gie_in   (gie_in),
        .itr      (itr),
        .itr_addr (itr_addr),
        .itr_id   (itr_id),
        .itr_ack  (itr_ack),
        .itr_ret  (itr_ret),
        .pend     (pend),
        .isr      (isr),
        .depth    (depth)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected request from the bench's own address model: 1 + 4*id.
    task automatic push_exp(input int id);
        exp_t e;
        e.id   = 2'(id);
        e.addr = 9'(1 + 4 * id);
        exp_q.push_back(e);
    endtask

    task automatic wait_itr(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (itr === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; irq = '0; mask_wr = 1'b0; mask_in = '0;
        gie_wr = 1'b0; gie_in = 1'b0; itr_ack = 1'b0; itr_ret = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic enable_all();
        mask_wr = 1'b1; mask_in = 4'b0000; gie_wr = 1'b1; gie_in = 1'b1;
        tick();
        mask_wr = 1'b0; gie_wr = 1'b0;
    endtask

    task automatic ack_cycle();
        itr_ack = 1'b1; tick(); itr_ack = 1'b0;
    endtask

    task automatic ret_cycle();
        itr_ret = 1'b1; tick(); itr_ret = 1'b0;
    endtask

    task automatic test_reset();
        bit   ok;
        exp_t e;
        do_reset();
        total++; if (itr !== 1'b0)      begin bad++; $display("FAIL rst_itr: got %b want 0", itr); end
        total++; if (itr_id !== 2'd0)   begin bad++; $display("FAIL rst_id: got %0d want 0", itr_id); end
        total++; if (itr_addr !== 9'd1) begin bad++; $display("FAIL rst_addr: got %0d want 1", itr_addr); end
        total++; if (pend !== 4'b0 || isr !== 4'b0 || depth !== 3'd0)
            begin bad++; $display("FAIL rst_state: pend=%b isr=%b depth=%0d want 0/0/0", pend, isr, depth); end
        // Masked and disabled out of reset: an edge only pends.
        irq = 4'b0100; tick(4);
        total++; if (itr !== 1'b0 || pend !== 4'b0100)
            begin bad++; $display("FAIL rst_masked: itr=%b pend=%b want 0/0100", itr, pend); end
        gie_wr = 1'b1; gie_in = 1'b1; tick(); gie_wr = 1'b0; tick(3);
        total++; if (itr !== 1'b0) begin bad++; $display("FAIL rst_mask_ones: itr=%b want 0", itr); end
        push_exp(2);
        mask_wr = 1'b1; mask_in = 4'b0000; tick(); mask_wr = 1'b0;
        wait_itr(ok); e = exp_q.pop_front();
        total++; if (!ok || itr_id !== e.id || itr_addr !== e.addr)
            begin bad++; $display("FAIL rst_unmask_req: itr=%b id=%0d addr=%0d want id=%0d addr=%0d", itr, itr_id, itr_addr, e.id, e.addr); end
    endtask

    task automatic test_basic();
        exp_t e;
        do_reset(); enable_all();
        push_exp(2);
        irq = 4'b0100; tick();
        total++; if (pend !== 4'b0100 || itr !== 1'b0)
            begin bad++; $display("FAIL basic_pend: pend=%b itr=%b want 0100/0", pend, itr); end
        tick();
        e = exp_q.pop_front();
        total++; if (itr !== 1'b1 || itr_id !== e.id || itr_addr !== e.addr)
            begin bad++; $display("FAIL basic_req: itr=%b id=%0d addr=%0d want 1/%0d/%0d", itr, itr_id, itr_addr, e.id, e.addr); end
        ack_cycle();
        total++; if (itr !== 1'b0 || pend[2] !== 1'b0 || isr !== 4'b0100 || depth !== 3'd1)
            begin bad++; $display("FAIL basic_ack: itr=%b pend=%b isr=%b depth=%0d want 0/x0xx/0100/1", itr, pend, isr, depth); end
        ret_cycle();
        total++; if (isr !== 4'b0 || depth !== 3'd0)
            begin bad++; $display("FAIL basic_ret: isr=%b depth=%0d want 0000/0", isr, depth); end
    endtask

    task automatic test_priority();
        bit   ok;
        exp_t e;
        do_reset(); enable_all();
        push_exp(1); push_exp(3);
        irq = 4'b1010;
        wait_itr(ok); e = exp_q.pop_front();
        total++; if (!ok || itr_id !== e.id || itr_addr !== e.addr)
            begin bad++; $display("FAIL prio_first: itr=%b id=%0d addr=%0d want id=%0d addr=%0d", itr, itr_id, itr_addr, e.id, e.addr); end
        ack_cycle();
        irq = 4'b1000;
        tick(2);
        total++; if (itr !== 1'b0 || isr !== 4'b0010)
            begin bad++; $display("FAIL prio_blocked: itr=%b isr=%b want 0/0010", itr, isr); end
        ret_cycle();
        wait_itr(ok); e = exp_q.pop_front();
        total++; if (!ok || itr_id !== e.id || itr_addr !== e.addr)
            begin bad++; $display("FAIL prio_second: itr=%b id=%0d addr=%0d want id=%0d addr=%0d", itr, itr_id, itr_addr, e.id, e.addr); end
        ack_cycle(); ret_cycle();
        irq = 4'b0000;
    endtask

    task automatic test_nesting();
        bit   ok;
        exp_t e;
        do_reset(); enable_all();
        push_exp(2);
        irq = 4'b0100;
        wait_itr(ok); e = exp_q.pop_front();
        total++; if (!ok || itr_id !== e.id)
            begin bad++; $display("FAIL nest_src2: itr=%b id=%0d want id=%0d", itr, itr_id, e.id); end
        ack_cycle();
        irq = 4'b0101;
`ifdef ITR_NEST_EN
        push_exp(0);
        wait_itr(ok); e = exp_q.pop_front();
        total++; if (!ok || itr_id !== e.id || itr_addr !== e.addr)
            begin bad++; $display("FAIL nest_preempt: itr=%b id=%0d addr=%0d want id=%0d addr=%0d", itr, itr_id, itr_addr, e.id, e.addr); end
        ack_cycle();
        total++; if (depth !== 3'd2 || isr !== 4'b0101)
            begin bad++; $display("FAIL nest_depth2: depth=%0d isr=%b want 2/0101", depth, isr); end
        irq = 4'b1101; tick(4);
        total++; if (itr !== 1'b0) begin bad++; $display("FAIL nest_low_blk2: itr=%b want 0", itr); end
        ret_cycle(); tick(3);
        total++; if (itr !== 1'b0 || depth !== 3'd1)
            begin bad++; $display("FAIL nest_low_blk1: itr=%b depth=%0d want 0/1", itr, depth); end
        push_exp(3);
        ret_cycle();
`else
        tick(4);
        total++; if (itr !== 1'b0 || depth !== 3'd1)
            begin bad++; $display("FAIL nest_wait0: itr=%b depth=%0d want 0/1", itr, depth); end
        push_exp(0);
        ret_cycle();
        wait_itr(ok); e = exp_q.pop_front();
        total++; if (!ok || itr_id !== e.id || itr_addr !== e.addr)
            begin bad++; $display("FAIL nest_after_ret0: itr=%b id=%0d addr=%0d want id=%0d addr=%0d", itr, itr_id, itr_addr, e.id, e.addr); end
        ack_cycle();
        irq = 4'b1101; tick(4);
        total++; if (itr !== 1'b0 || depth !== 3'd1)
            begin bad++; $display("FAIL nest_wait3: itr=%b depth=%0d want 0/1", itr, depth); end
        push_exp(3);
        ret_cycle();
`endif
        wait_itr(ok); e = exp_q.pop_front();
        total++; if (!ok || itr_id !== e.id || itr_addr !== e.addr)
            begin bad++; $display("FAIL nest_src3: itr=%b id=%0d addr=%0d want id=%0d addr=%0d", itr, itr_id, itr_addr, e.id, e.addr); end
        ack_cycle(); ret_cycle();
        total++; if (depth !== 3'd0 || isr !== 4'b0)
            begin bad++; $display("FAIL nest_unwind: depth=%0d isr=%b want 0/0000", depth, isr); end
        irq = 4'b0000;
    endtask

    task automatic test_hold();
        bit   ok;
        exp_t e;
        do_reset(); enable_all();
        push_exp(2);
        irq = 4'b0100;
        wait_itr(ok);
        irq = 4'b0101;
        mask_wr = 1'b1; mask_in = 4'b0100; gie_wr = 1'b1; gie_in = 1'b0;
        tick();
        mask_wr = 1'b0; gie_wr = 1'b0;
        tick(4);
        e = exp_q.pop_front();
        total++; if (!ok || itr !== 1'b1 || itr_id !== e.id || itr_addr !== e.addr)
            begin bad++; $display("FAIL hold_req: itr=%b id=%0d addr=%0d want 1/%0d/%0d", itr, itr_id, itr_addr, e.id, e.addr); end
        ack_cycle(); ret_cycle(); tick(4);
        total++; if (itr !== 1'b0 || pend[0] !== 1'b1)
            begin bad++; $display("FAIL hold_gie_off: itr=%b pend=%b want 0/xxx1", itr, pend); end
        irq = 4'b0000;
    endtask

    task automatic test_level();
        bit   ok;
        exp_t e;
        do_reset(); enable_all();
        push_exp(1);
        irq = 4'b0010;
        wait_itr(ok); e = exp_q.pop_front();
        total++; if (!ok || itr_id !== e.id || itr_addr !== e.addr)
            begin bad++; $display("FAIL level_req: itr=%b id=%0d addr=%0d want id=%0d addr=%0d", itr, itr_id, itr_addr, e.id, e.addr); end
        ack_cycle(); tick(3);
        total++; if (pend[1] !== 1'b1 || itr !== 1'b0 || isr !== 4'b0010)
            begin bad++; $display("FAIL level_hold: pend=%b itr=%b isr=%b want xx1x/0/0010", pend, itr, isr); end
        push_exp(1);
        ret_cycle();
        wait_itr(ok); e = exp_q.pop_front();
        total++; if (!ok || itr_id !== e.id)
            begin bad++; $display("FAIL level_reissue: itr=%b id=%0d want id=%0d", itr, itr_id, e.id); end
        ack_cycle();
        irq = 4'b0000;
        ret_cycle(); ret_cycle();
        total++; if (depth !== 3'd0 || isr !== 4'b0)
            begin bad++; $display("FAIL level_ret_empty: depth=%0d isr=%b want 0/0000", depth, isr); end
    endtask

    task automatic test_reset_mid();
        bit   ok;
        exp_t e;
        do_reset(); enable_all();
        irq = 4'b0100;
        wait_itr(ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_req: itr=%b want 1", itr); end
        rst = 1'b1; tick(); rst = 1'b0;
        total++; if (itr !== 1'b0 || pend !== 4'b0 || isr !== 4'b0 || depth !== 3'd0)
            begin bad++; $display("FAIL mid_reset: itr=%b pend=%b isr=%b depth=%0d want 0/0/0/0", itr, pend, isr, depth); end
        irq = 4'b0000;
        enable_all();
`ifdef ITR_NEST_EN
        push_exp(2);
        irq = 4'b0100;
        wait_itr(ok); e = exp_q.pop_front();
        ack_cycle();
        push_exp(0);
        irq = 4'b0101;
        wait_itr(ok); e = exp_q.pop_front();
        total++; if (!ok || itr_id !== e.id)
            begin bad++; $display("FAIL mid_req0: itr=%b id=%0d want id=%0d", itr, itr_id, e.id); end
        itr_ack = 1'b1; itr_ret = 1'b1; tick(); itr_ack = 1'b0; itr_ret = 1'b0;
        total++; if (depth !== 3'd1 || isr !== 4'b0001)
            begin bad++; $display("FAIL mid_ret_ack: depth=%0d isr=%b want 1/0001", depth, isr); end
`else
        push_exp(2);
        irq = 4'b0100;
        wait_itr(ok); e = exp_q.pop_front();
        total++; if (!ok || itr_id !== e.id)
            begin bad++; $display("FAIL mid_req2: itr=%b id=%0d want id=%0d", itr, itr_id, e.id); end
        itr_ack = 1'b1; itr_ret = 1'b1; tick(); itr_ack = 1'b0; itr_ret = 1'b0;
        total++; if (depth !== 3'd1 || isr !== 4'b0100)
            begin bad++; $display("FAIL mid_ret_ack: depth=%0d isr=%b want 1/0100", depth, isr); end
`endif
        irq = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_nesting();
        test_hold();
        test_level();
        test_reset_mid();
        total++; if (exp_q.size() != 0)
            begin bad++; $display("FAIL scoreboard_left: %0d entries want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/itr_ctrl.md
Name: itr_ctrl

Overview:
- Multi-source vectored interrupt controller for the fixed-point stack-processor core; replaces the single `itr` line with its single fixed ISR address.
- Accepts NITR interrupt sources with per-source edge or level mode, a mask and a global enable.
- Issues one prioritised request at a time, with a vector address, toward the core's PC/prefetch.
- Tracks in-service interrupts so that nested preemption and return-from-interrupt behave correctly.

Parameters:
- NITR, 4, number of interrupt sources (2..16); index 0 has the highest priority.
- MINSTW, 9, instruction address width.
- ITRADD, 1, vector base address.
- ITRSTP, 4, address distance between consecutive vectors.
- ITRMOD, 4'b1111, per-source mode bitmask: 1 = rising-edge latched, 0 = level.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- irq  in  NITR  interrupt sources; synchronous to clk.
- mask_wr  in  1  load mask register from mask_in.
- mask_in  in  NITR  mask value; 1 = source masked.
- gie_wr  in  1  load global enable from gie_in.
- gie_in  in  1  global interrupt enable value.
- itr  out  1  interrupt request to the core.
- itr_addr  out  MINSTW  vector address of the requested source.
- itr_id  out  $clog2(NITR)  index of the requested source.
- itr_ack  in  1  core has jumped to itr_addr.
- itr_ret  in  1  core executes return-from-interrupt.
- pend  out  NITR  pending vector.
- isr  out  NITR  in-service vector.
- depth  out  $clog2(NITR+1)  current nesting depth.

Behaviour:
- Reset, while rst=1 at a clk edge:
  - itr=0, itr_id=0, itr_addr=ITRADD, pend=0, isr=0, depth=0.
  - mask=all ones, gie=0, irq_d=0, FSM=IDLE.
  - Reset mid-request discards the request; the core sees itr=0 on the following cycle.
- Pending:
  - Edge source k: pend[k] sets on irq[k]&~irq_d[k] and clears on itr_ack with itr_id==k.
  - If a new edge and the ack for the same k occur in the same cycle, pend[k] stays 1.
  - Level source k: pend[k] is the registered irq[k]; ack does not clear it, the ISR clears the source.
- Eligibility: elig = pend & ~mask & {NITR{gie}}, further gated by nesting (see Optional Feature). Winner = lowest set index of elig.
- FSM:
  - IDLE: if elig≠0, latch winner into itr_id, register itr=1 and itr_addr, go to REQ.
  - REQ: itr, itr_id and itr_addr are held stable until itr_ack. Higher-priority arrivals, mask writes and gie=0 do not withdraw or change the request.
  - On itr_ack in REQ: set isr[itr_id], depth+1, itr=0 at the next edge, go to IDLE.
  - itr_ack outside REQ is ignored.
- Latency: irq edge sampled at edge n → pend visible after n → itr high after n+1. After an ack, the earliest re-request is 1 cycle later (IDLE re-evaluates).
- itr_ret: clears the lowest set bit of isr and decrements depth. itr_ret with isr=0 is ignored; depth never underflows.
- Simultaneous itr_ret and itr_ack: the ret clear is applied to the old isr first, then the ack bit is set; depth is unchanged net.
- itr_addr = (ITRADD + itr_id*ITRSTP) mod 2^MINSTW, computed at MINSTW width.
- mask_wr and gie_wr take effect for eligibility on the next cycle.

Optional Feature:
- ITR_NEST_EN defined: a source is eligible only if its index is below the lowest set index of isr (strict preemption). depth ranges 0..NITR.
- ITR_NEST_EN undefined: elig is forced to 0 while isr≠0, so at most one interrupt is in service and depth is 0 or 1. An ack while isr≠0 is impossible by construction.

Decomposition:
- Package itr_pkg holds:
  - FSM state enum (IDLE, REQ).
  - Function computing the vector address.
  - Localparam widths derived from NITR.
- One natural sub-module: prio_enc (lowest-set-bit finder, NITR in → index plus valid out), instanced twice: on elig and on isr.

Test Plan:
- Reset, gie=1, mask=0, rising edge on irq[2] at cycle 10 → itr=1 at cycle 12, itr_id=2, itr_addr=9; ack → pend[2]=0, isr=4'b0100, depth=1.
- Edges on irq[3] and irq[1] in the same cycle → first request has itr_id=1, addr=5; after ack and ret, a second request follows with itr_id=3, addr=13.
- ITR_NEST_EN: source 2 in service, edge on irq[0] → itr with id 0 and depth→2; edge on irq[3] → no request until depth returns to 0. Without the macro, irq[0] also waits until ret.
- Request pending on id 2, then mask_in=4'b0100 and gie=0 before ack → itr stays 1 with id 2; after ack, no further request while gie=0.
- Level source (ITRMOD bit 1=0) held high across ack → pend[1] remains 1; request re-issues after ret. itr_ret with isr=0 → depth stays 0.
- rst asserted while in REQ → next cycle itr=0 and pend, isr, depth all 0; same-cycle ret+ack → depth unchanged.
